// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM responder model and the test logic.
// Latency helpers here also set the test logic's timeout and 2x thresholds.
package psram_pkg;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        WAIT
    } state_e;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting Fibonacci LFSR
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [5:0] wr_cycles(input int lat, input logic dbl);
        return dbl ? 6'(2 + 2 * lat) : 6'(2 + lat);
    endfunction

    function automatic logic [5:0] rd_cycles(input int lat, input logic dbl);
        return dbl ? 6'(7 + 2 * lat) : 6'(7 + lat);
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/psram_model_mem.sv
// Single-port 16-bit backing store with byte enables and a registered read.
// No reset on the array or the read register so it maps onto block RAM.
module psram_model_mem
    import psram_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [1:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            if (be[0]) mem[addr][7:0] <= wdata[7:0];
            if (be[1]) mem[addr][15:8] <= wdata[15:8];
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/psram_responder_model.sv
// Block-RAM stand-in for the PSRAM controller command interface,
// reproducing its busy timing and pseudo-random 1x/2x latency.
module psram_responder_model
    import psram_pkg::*;
#(
    parameter int LATENCY     = 3,
    parameter int DEPTH_LOG2  = 10,
    parameter int INIT_CYCLES = 64,
    parameter int DBL_EN      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic        byte_write,
    input  logic [21:0] addr,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        busy,
    output logic        dbl_latency,
    output logic        protocol_err
);

    localparam int IW = $clog2(INIT_CYCLES + 1);

    state_e                state_q, state_d;
    logic [5:0]            cnt_q, cnt_d;
    logic [IW-1:0]         icnt_q, icnt_d;
    logic                  busy_q, busy_d;
    logic                  dbl_q, dbl_d;
    logic                  perr_q, perr_d;
    logic [7:0]            lfsr_q, lfsr_d;
    logic [15:0]           dout_q, dout_d;
    logic                  rd_q, rd_d;
    logic                  we_q, we_d;
    logic [1:0]            be_q, be_d;
    logic [DEPTH_LOG2-1:0] addr_q, addr_d;
    logic [15:0]           wdata_q, wdata_d;

    logic [7:0]  lfsr_n;
    logic        dbl_n;
    logic        req;
    logic [15:0] rdata;
    logic        unused_addr;

    assign lfsr_n      = lfsr_next(lfsr_q);
    assign dbl_n       = (DBL_EN != 0) && (lfsr_n[1:0] == 2'b00);
    assign req         = read | write;
    assign unused_addr = ^addr[21:DEPTH_LOG2+1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        icnt_d  = icnt_q;
        busy_d  = busy_q;
        dbl_d   = dbl_q;
        perr_d  = perr_q;
        lfsr_d  = lfsr_q;
        dout_d  = dout_q;
        rd_d    = rd_q;
        we_d    = 1'b0;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            INIT: begin
                if (req) perr_d = 1'b1;
                if (icnt_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    icnt_d = icnt_q - IW'(1);
                end
            end
            IDLE: begin
                if (req) begin
                    lfsr_d  = lfsr_n;
                    state_d = WAIT;
                    busy_d  = 1'b1;
                    dbl_d   = dbl_n;
                    rd_d    = read & ~write;
                    we_d    = write;
                    addr_d  = addr[DEPTH_LOG2:1];
                    wdata_d = din;
                    be_d    = !byte_write ? 2'b11 :
                              addr[0]     ? 2'b10 : 2'b01;
                    cnt_d   = (write ? wr_cycles(LATENCY, dbl_n)
                                     : rd_cycles(LATENCY, dbl_n)) - 6'd1;
                    if (read && write) perr_d = 1'b1;
                end
            end
            WAIT: begin
                if (req) perr_d = 1'b1;
                if (cnt_q == 6'd0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    dbl_d   = 1'b0;
                    if (rd_q) dout_d = rdata;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
            icnt_q  <= IW'(INIT_CYCLES - 1);
            busy_q  <= 1'b1;
            dbl_q   <= 1'b0;
            perr_q  <= 1'b0;
            lfsr_q  <= LFSR_SEED;
            dout_q  <= '0;
            rd_q    <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            icnt_q  <= icnt_d;
            busy_q  <= busy_d;
            dbl_q   <= dbl_d;
            perr_q  <= perr_d;
            lfsr_q  <= lfsr_d;
            dout_q  <= dout_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    psram_model_mem #(.AW(DEPTH_LOG2)) u_mem (
        .clk   (clk),
        .we    (we_q),
        .be    (be_q),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (rdata)
    );

    assign dout         = dout_q;
    assign busy         = busy_q;
    assign dbl_latency  = dbl_q;
    assign protocol_err = perr_q;

endmodule
